seg_scan_mux: RTL
=================

Name: seg_scan_mux

Overview:
- Upstream feeder for the 7-segment decoder; time-multiplexes N_DIGITS 4-bit digit codes onto one shared decoder input.
- Drives active-low digit anodes in round-robin order.
- Inserts a blanking gap at the start of every digit slot to suppress ghosting.
- Blank code 4'hF falls into the decoder's all-segments-off default.

Parameters:
- N_DIGITS, 4: number of multiplexed digits, >=2.
- SCAN_DIV, 50000: clock cycles per digit slot, >=2.
- BLANK_CYCLES, 16: cycles at the start of each slot with all anodes off; 0 = no blanking; must be < SCAN_DIV.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- digits_in  input  4*N_DIGITS  digit codes; digit k at bits [4k+3:4k]; digit 0 = least significant/rightmost.
- load  input  1  when high at a clk edge, digits_in is captured into the shadow register.
- digit_code  output  4  registered code to the decoder's sw input.
- an  output  N_DIGITS  registered active-low anode enables; an[k]=0 lights digit k.
- digit_idx  output  clog2(N_DIGITS)  registered index of the digit currently driven.
- frame_tick  output  1  registered one-cycle pulse per completed scan frame.

Behaviour:
- Reset (async, immediate):
  - Internal state: cnt=0, idx=0, digits_q=0.
  - Outputs: an=all ones, digit_code=4'hF, digit_idx=0, frame_tick=0.
  - Reset mid-slot aborts the scan; the first slot after release is digit 0 starting in BLANK.
- Shadow register: digits_q <= digits_in on any edge with load=1; otherwise held. No value filtering; codes 10-15 pass through and are blanked by the decoder.
- Prescaler:
  - cnt counts 0..SCAN_DIV-1 and wraps to 0.
  - On wrap, idx <= idx+1, or 0 when idx==N_DIGITS-1.
- Phase (derived from current cnt):
  - BLANK when cnt < BLANK_CYCLES.
  - ON otherwise.
  - Per slot: BLANK -> ON at cnt==BLANK_CYCLES; ON -> BLANK at wrap.
  - With BLANK_CYCLES=0, BLANK never occurs.
- Output register: every edge, outputs are computed from current cnt, idx, digits_q.
  - BLANK: an=all ones, digit_code=4'hF.
  - ON: an has only bit idx low; digit_code=digits_q[4*idx+:4].
  - digit_idx <= idx in both phases.
  - Outputs lag internal state by exactly 1 cycle.
  - Never more than one anode low in any cycle.
- Load latency: load sampled at edge E updates digits_q at E. If the slot is in ON, digit_code reflects the new value at edge E+1. Mid-slot updates are permitted with no deferral.
- frame_tick:
  - Set to 1 on the edge where idx wraps N_DIGITS-1 -> 0; 0 on all other edges.
  - Period = N_DIGITS*SCAN_DIV cycles.
  - First pulse after reset comes at cycle N_DIGITS*SCAN_DIV.
- Simultaneous load and slot wrap: both take effect at the same edge. The next slot shows the new value once it reaches ON.

Optional Feature:
- Macro: SEG_SCAN_LZB_EN (leading-zero blanking).
- Defined:
  - During ON, digit k with k>0 outputs digit_code=4'hF if digits_q digit k and all higher digits equal 4'h0.
  - Its anode is still asserted, so scan timing is unchanged.
  - Digit 0 is never blanked; all-zero input shows a single "0".
  - The blanking decision uses the same digits_q value used for digit_code in that cycle.
- Undefined: every digit is displayed as stored, including leading zeros.

Test Plan:
All tests use N_DIGITS=4, SCAN_DIV=8, BLANK_CYCLES=2 unless stated.
1. Reset values: assert rst asynchronously mid-cycle -> an=4'b1111, digit_code=4'hF, digit_idx=0, frame_tick=0 immediately, before the next edge. After release, the first ON output appears 3 edges later, with an=4'b1110.
2. Scan order: load digits_in=16'h4321 -> over 32 cycles, digit_code is 1,2,3,4 with an=1110,1101,1011,0111 respectively. Each slot has 2 cycles of an=1111/code F, then 6 ON cycles.
3. frame_tick: free-run 100 cycles -> pulses exactly at cycles 32, 64 and 96 after reset release, each one cycle wide.
4. Mid-slot load: during digit-1 ON, load 16'h0090 -> digit_code changes 2->9 exactly one cycle after the load edge; an is unchanged.
5. Reset mid-operation: assert rst during the digit-2 ON phase for 1 cycle -> scan restarts at digit 0 BLANK, and digits_q=0 so digit_code=0 in ON.
6. With SEG_SCAN_LZB_EN and digits_in=16'h0205:
   - ON codes are 5,0,2,F.
   - With 16'h0000: codes are 0,F,F,F.
   - Without the macro, 16'h0205 gives 5,0,2,0.

Source files
------------

// File: rtl/seg_scan_mux_if.sv
// seg_scan_mux_if: digit load inputs and scan outputs of the 7-segment scan multiplexer
//   master: drives digits_in/load, observes digit_code/an/digit_idx/frame_tick
//   slave:  the multiplexer side
interface seg_scan_mux_if #(
    parameter int N_DIGITS = 4
);
    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    logic [4*N_DIGITS-1:0] digits_in;
    logic                  load;
    logic [3:0]            digit_code;
    logic [N_DIGITS-1:0]   an;
    logic [IW-1:0]         digit_idx;
    logic                  frame_tick;
    modport master (output digits_in, load, input digit_code, an, digit_idx, frame_tick);
    modport slave  (input digits_in, load, output digit_code, an, digit_idx, frame_tick);
endinterface

// File: rtl/seg_scan_mux.sv
// seg_scan_mux: round-robin scan of N_DIGITS 4-bit codes onto one decoder input with per-slot blanking
//   clk, rst (async, active-high); bus.slave: digits_in/load in, digit_code/an (active-low)/digit_idx/frame_tick out
//   SEG_SCAN_LZB_EN: when defined, leading zeros above digit 0 are shown as blank code 4'hF
module seg_scan_mux #(
    parameter int N_DIGITS     = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    seg_scan_mux_if.slave bus
);
    localparam int CW = $clog2(SCAN_DIV);
    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    logic [CW-1:0]         r_cnt;
    logic [IW-1:0]         r_idx;
    logic [4*N_DIGITS-1:0] r_digits;
    logic [N_DIGITS-1:0]   r_an;
    logic [3:0]            r_code;
    logic [IW-1:0]         r_digit_idx;
    logic                  r_frame_tick;
    logic                  w_wrap;
    logic                  w_on;
    logic [3:0]            w_raw;
    logic [3:0]            w_code;
    assign w_wrap = r_cnt == CW'(SCAN_DIV - 1);
    assign w_on   = int'(r_cnt) >= BLANK_CYCLES;
    assign w_raw  = r_digits[4*r_idx +: 4];
`ifdef SEG_SCAN_LZB_EN
    // w_lz[k]: digit k and every digit above it are zero
    logic [N_DIGITS-1:0] w_lz;
    always_comb begin
        w_lz = '0;
        w_lz[N_DIGITS-1] = r_digits[4*N_DIGITS-1 -: 4] == 4'h0;
        for (int k = N_DIGITS - 2; k >= 0; k--) w_lz[k] = w_lz[k+1] && r_digits[4*k +: 4] == 4'h0;
    end
    assign w_code = (r_idx != '0 && w_lz[r_idx]) ? 4'hF : w_raw;
`else
    assign w_code = w_raw;
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt        <= '0;
            r_idx        <= '0;
            r_digits     <= '0;
            r_an         <= '1;
            r_code       <= 4'hF;
            r_digit_idx  <= '0;
            r_frame_tick <= 1'b0;
        end else begin
            if (bus.load) r_digits <= bus.digits_in;
            r_cnt        <= w_wrap ? '0 : r_cnt + CW'(1);
            if (w_wrap) r_idx <= (r_idx == IW'(N_DIGITS - 1)) ? '0 : r_idx + IW'(1);
            r_an         <= w_on ? ~(N_DIGITS'(1) << r_idx) : '1;
            r_code       <= w_on ? w_code : 4'hF;
            r_digit_idx  <= r_idx;
            r_frame_tick <= w_wrap && r_idx == IW'(N_DIGITS - 1);
        end
    end
    assign bus.an         = r_an;
    assign bus.digit_code = r_code;
    assign bus.digit_idx  = r_digit_idx;
    assign bus.frame_tick = r_frame_tick;
endmodule
